fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch from the byte-wide, async-read instruction memory:
//  issues 4 byte reads per instruction, assembles a 32-bit word, and presents it to decode.
//  Owns the program counter (PC). Supports a valid/ready handshake toward decode,
//  a redirect (branch/jump) path, and run/idle control.
//  Sits between the instruction Memory and the decode stage.
//  Replaces the free-running PC + adder pair.
// PARAMETERS
//  ADDR_W    32     width of PC and memory byte address
//  RESET_PC  0      PC value loaded on reset; must be 4-byte aligned
// PORTS
//  CLK            in   1       clock, rising edge
//  RST            in   1       asynchronous reset, active-high
//  run            in   1       1 = fetch enabled; sampled in IDLE and on accept
//  redirect_valid in   1       1 = load redirect_pc this cycle
//  redirect_pc    in   ADDR_W  new PC; bits [1:0] ignored (forced 0)
//  mem_addr       out  ADDR_W  byte address to Memory
//  mem_data       in   8       byte from Memory, combinational w.r.t. mem_addr
//  ins_out        out  32      assembled instruction, stable while ins_valid=1
//  ins_pc         out  ADDR_W  address of the instruction in ins_out
//  ins_valid      out  1       ins_out holds a complete instruction
//  ins_ready      in   1       decode accepts ins_out
//  busy           out  1       1 when state != IDLE
// BEHAVIOUR
//  Reset (async, RST=1): state=IDLE, pc=RESET_PC, cnt=0, ins_out=0, ins_pc=RESET_PC,
//   ins_valid=0, busy=0. All registers reset; RST mid-fetch discards the partial word.
//  State machine: IDLE, FETCH, VALID. Byte counter cnt[1:0].
//  IDLE: mem_addr=pc. If run=1, next state is FETCH with cnt=0.
//  FETCH: mem_addr = pc + cnt (mod 2^ADDR_W). Each edge captures mem_data.
//   Byte order is big-endian: cnt0->ins[31:24], cnt1->[23:16], cnt2->[15:8], cnt3->[7:0].
//   cnt increments each cycle. After capturing cnt=3, go to VALID with ins_valid=1 and ins_pc=pc.
//   run=0 mid-FETCH does not abort; the word completes.
//  VALID: mem_addr=pc; ins_out/ins_pc held. Transfer = ins_valid & ins_ready & ~redirect_valid.
//   On transfer: pc <= pc+4 (wraps mod 2^ADDR_W), ins_valid <= 0, and
//   next state = FETCH (cnt=0) if run=1, otherwise IDLE.
//   No transfer: hold all outputs.
//  Latency: run rises in IDLE -> ins_valid=1 exactly 5 edges later (1 IDLE->FETCH, 4 byte captures).
//   With ins_ready held at 1 and no redirects, one instruction is delivered every 5 cycles.
//  Redirect (highest priority, any state): pc <= {redirect_pc[ADDR_W-1:2],2'b00},
//   cnt <= 0, ins_valid <= 0, partial or held word discarded (no transfer, even if ins_ready=1).
//   Next state = FETCH if run=1, else IDLE.
//  Address wrap: pc=2^ADDR_W-4 -> bytes fetched at ..FC..FF; next pc=0.
//  ins_out keeps its last value when ins_valid=0; not cleared except by reset.
// TESTING
//  T1 reset/latency: mem[0..3]=8'h12,34,56,78; RST pulse, run=1, ins_ready=0
//   -> mem_addr 0,1,2,3 on FETCH cycles; 5th edge ins_valid=1, ins_out=32'h12345678, ins_pc=0.
//  T2 backpressure/stream: hold ins_ready=0 for 3 cycles -> outputs stable;
//   then ins_ready=1 -> next word from addr 4, ins_pc=4, one word per 5 cycles.
//  T3 redirect: redirect_valid=1, redirect_pc=32'h0000_0043 during FETCH cnt=2
//   -> next mem_addr=32'h40, ins_valid=0, and the following word has ins_pc=32'h40.
//  T4 redirect vs accept: ins_valid=1, ins_ready=1, redirect_valid=1 (pc=32'h80) same cycle
//   -> no transfer counted, pc=32'h80, FETCH restarts.
//  T5 run drop: run=0 at FETCH cnt=1 -> word completes, VALID; accept -> IDLE, busy=0, pc+=4.
//  T6 wrap + async reset: RESET_PC=32'hFFFF_FFFC -> addrs FC..FF, after accept pc=0;
//   assert RST mid-FETCH (off-edge) -> outputs reset immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: four async byte reads per word, big-endian assembly,
// valid/ready handoff to decode, redirect path and run/idle control. Owns the PC.
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [31:0]       ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        cnt;
    logic [23:0]       word_buf;
    logic              xfer;

    assign xfer = ins_valid & ins_ready & ~redirect_valid;
    assign busy = (state != IDLE);

    always_comb begin
        mem_addr = pc;
        if (state == FETCH) begin
            mem_addr = pc + {{(ADDR_W-2){1'b0}}, cnt};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Redirect outranks everything, including a same-cycle accept in VALID.
    always_comb begin
        next_state = state;
        if (redirect_valid) begin
            next_state = run ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE:    if (run) next_state = FETCH;
                FETCH:   if (cnt == 2'd3) next_state = VALID;
                VALID:   if (xfer) next_state = run ? FETCH : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // The first three bytes collect in word_buf so ins_out only changes when a full word lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            cnt       <= 2'd0;
            word_buf  <= 24'd0;
            ins_out   <= 32'd0;
            ins_pc    <= RESET_PC;
            ins_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc & ~ADDR_W'(3);
            cnt       <= 2'd0;
            ins_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 2'd0;
                end
                FETCH: begin
                    cnt <= cnt + 2'd1;
                    case (cnt)
                        2'd0: word_buf[23:16] <= mem_data;
                        2'd1: word_buf[15:8]  <= mem_data;
                        2'd2: word_buf[7:0]   <= mem_data;
                        default: begin
                            ins_out   <= {word_buf, mem_data};
                            ins_pc    <= pc;
                            ins_valid <= 1'b1;
                        end
                    endcase
                end
                VALID: begin
                    if (xfer) begin
                        pc        <= pc + ADDR_W'(4);
                        cnt       <= 2'd0;
                        ins_valid <= 1'b0;
                    end
                end
                default: begin
                    cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer, plus a wrap/async-reset sequence
// on a second instance whose reset PC sits at the top of the address space.
module tb_fetch_sequencer;

    typedef struct {
        logic        run;
        logic        rdv;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic        busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, run, redirect_valid, ins_ready;
    logic [31:0] redirect_pc, mem_addr, ins_out, ins_pc;
    logic [7:0]  mem_data;
    logic        ins_valid, busy;

    logic        rst_w, run_w, redirect_valid_w, ins_ready_w;
    logic [31:0] redirect_pc_w, mem_addr_w, ins_out_w, ins_pc_w;
    logic [7:0]  mem_data_w;
    logic        ins_valid_w, busy_w;

    logic [7:0]  mem [256];
    vec_t        vecs [$];
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    // Byte memory aliases every 256 bytes, so address FFFF_FFFC reads mem[FC].
    assign mem_data   = mem[mem_addr[7:0]];
    assign mem_data_w = mem[mem_addr_w[7:0]];

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .run(run),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .ins_out(ins_out), .ins_pc(ins_pc), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .busy(busy)
    );

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst_w), .run(run_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .mem_addr(mem_addr_w), .mem_data(mem_data_w),
        .ins_out(ins_out_w), .ins_pc(ins_pc_w), .ins_valid(ins_valid_w),
        .ins_ready(ins_ready_w), .busy(busy_w)
    );

    task automatic check_output(input string name, input int idx,
                                input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s @%0d: got %h, expected %h", name, idx, actual, expected);
        end
    endtask

    task automatic add_vec(input logic r, input logic dv, input logic [31:0] dpc, input logic rdy,
                           input logic [31:0] a, input logic v, input logic [31:0] w,
                           input logic [31:0] p, input logic b);
        vec_t t;
        t.run = r; t.rdv = dv; t.rpc = dpc; t.ready = rdy;
        t.addr = a; t.valid = v; t.ins = w; t.ipc = p; t.busy = b;
        vecs.push_back(t);
    endtask

    task automatic apply_stimulus(input vec_t t);
        run            = t.run;
        redirect_valid = t.rdv;
        redirect_pc    = t.rpc;
        ins_ready      = t.ready;
    endtask

    task automatic check_wrap(input string name, input int idx, input logic [31:0] a,
                              input logic v, input logic [31:0] w, input logic [31:0] p,
                              input logic b);
        check_output({name, ".mem_addr"},  idx, mem_addr_w, a);
        check_output({name, ".ins_valid"}, idx, {31'd0, ins_valid_w}, {31'd0, v});
        check_output({name, ".ins_out"},   idx, ins_out_w, w);
        check_output({name, ".ins_pc"},    idx, ins_pc_w, p);
        check_output({name, ".busy"},      idx, {31'd0, busy_w}, {31'd0, b});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;

        //      run rdv rpc           rdy addr          v  ins           ipc           busy
        add_vec(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0); // reset state
        add_vec(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0); // run rises in IDLE
        add_vec(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1);
        add_vec(1, 0, 32'h0,        0, 32'h1,        0, 32'h0,        32'h0,        1);
        add_vec(1, 0, 32'h0,        0, 32'h2,        0, 32'h0,        32'h0,        1);
        add_vec(1, 0, 32'h0,        0, 32'h3,        0, 32'h0,        32'h0,        1);
        add_vec(1, 0, 32'h0,        0, 32'h0,        1, 32'h12345678, 32'h0,        1); // 5 edges later
        add_vec(1, 0, 32'h0,        0, 32'h0,        1, 32'h12345678, 32'h0,        1); // backpressure
        add_vec(1, 0, 32'h0,        0, 32'h0,        1, 32'h12345678, 32'h0,        1);
        add_vec(1, 0, 32'h0,        1, 32'h0,        1, 32'h12345678, 32'h0,        1); // accept
        add_vec(1, 0, 32'h0,        1, 32'h4,        0, 32'h12345678, 32'h0,        1);
        add_vec(1, 0, 32'h0,        1, 32'h5,        0, 32'h12345678, 32'h0,        1);
        add_vec(1, 0, 32'h0,        1, 32'h6,        0, 32'h12345678, 32'h0,        1);
        add_vec(1, 0, 32'h0,        1, 32'h7,        0, 32'h12345678, 32'h0,        1);
        add_vec(1, 0, 32'h0,        1, 32'h4,        1, 32'h04050607, 32'h4,        1); // streamed word
        add_vec(1, 0, 32'h0,        1, 32'h8,        0, 32'h04050607, 32'h4,        1);
        add_vec(1, 0, 32'h0,        1, 32'h9,        0, 32'h04050607, 32'h4,        1);
        add_vec(1, 1, 32'h43,       1, 32'hA,        0, 32'h04050607, 32'h4,        1); // redirect at cnt=2
        add_vec(1, 0, 32'h0,        0, 32'h40,       0, 32'h04050607, 32'h4,        1);
        add_vec(1, 0, 32'h0,        0, 32'h41,       0, 32'h04050607, 32'h4,        1);
        add_vec(1, 0, 32'h0,        0, 32'h42,       0, 32'h04050607, 32'h4,        1);
        add_vec(1, 0, 32'h0,        0, 32'h43,       0, 32'h04050607, 32'h4,        1);
        add_vec(1, 1, 32'h80,       1, 32'h40,       1, 32'h40414243, 32'h40,       1); // redirect beats accept
        add_vec(1, 0, 32'h0,        0, 32'h80,       0, 32'h40414243, 32'h40,       1);
        add_vec(0, 0, 32'h0,        0, 32'h81,       0, 32'h40414243, 32'h40,       1); // run drops cnt=1
        add_vec(0, 0, 32'h0,        0, 32'h82,       0, 32'h40414243, 32'h40,       1);
        add_vec(0, 0, 32'h0,        0, 32'h83,       0, 32'h40414243, 32'h40,       1);
        add_vec(0, 0, 32'h0,        1, 32'h80,       1, 32'h80818283, 32'h80,       1); // accept -> IDLE
        add_vec(0, 0, 32'h0,        0, 32'h84,       0, 32'h80818283, 32'h80,       0);
        add_vec(0, 0, 32'h0,        0, 32'h84,       0, 32'h80818283, 32'h80,       0);
        add_vec(0, 1, 32'h102,      0, 32'h84,       0, 32'h80818283, 32'h80,       0); // redirect while idle
        add_vec(0, 0, 32'h0,        0, 32'h100,      0, 32'h80818283, 32'h80,       0);

        rst = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
        rst_w = 1'b1; run_w = 1'b0; redirect_valid_w = 1'b0; redirect_pc_w = '0; ins_ready_w = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rst_w = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output("mem_addr",  i, mem_addr, vecs[i].addr);
            check_output("ins_valid", i, {31'd0, ins_valid}, {31'd0, vecs[i].valid});
            check_output("ins_out",   i, ins_out, vecs[i].ins);
            check_output("ins_pc",    i, ins_pc, vecs[i].ipc);
            check_output("busy",      i, {31'd0, busy}, {31'd0, vecs[i].busy});
        end

        // Wrap instance: top-of-memory word, PC rolls over to 0, then async reset mid-fetch.
        @(negedge clk); #1;
        check_wrap("wrap_reset", 0, 32'hFFFF_FFFC, 0, 32'h0, 32'hFFFF_FFFC, 0);
        run_w = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check_wrap("wrap_fetch", k, 32'hFFFF_FFFC + 32'(k), 0, 32'h0, 32'hFFFF_FFFC, 1);
        end
        @(negedge clk); #1;
        check_wrap("wrap_valid", 0, 32'hFFFF_FFFC, 1, 32'hFCFDFEFF, 32'hFFFF_FFFC, 1);
        ins_ready_w = 1'b1;
        @(negedge clk); #1;
        ins_ready_w = 1'b0;
        check_wrap("wrap_pc0", 0, 32'h0, 0, 32'hFCFDFEFF, 32'hFFFF_FFFC, 1);
        @(negedge clk); #1;
        check_wrap("wrap_pc0", 1, 32'h1, 0, 32'hFCFDFEFF, 32'hFFFF_FFFC, 1);
        rst_w = 1'b1;
        #1;
        check_wrap("async_rst", 0, 32'hFFFF_FFFC, 0, 32'h0, 32'hFFFF_FFFC, 0);
        @(negedge clk);
        rst_w = 1'b0;
        run_w = 1'b0;
        #1;
        check_wrap("after_rst", 0, 32'hFFFF_FFFC, 0, 32'h0, 32'hFFFF_FFFC, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
